// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and the count-width helper
// used by the FIFO family and its benches.
package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Occupancy runs 0..depth inclusive, so it needs one more code than depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of arbitrary depth with standard/FWFT read modes, fill
// count, programmable almost flags, synchronous flush and error pulses.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int FWFT       = MODE_STD,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [CNT_W-1:0]      afull_th,
  input  logic [CNT_W-1:0]      aempty_th,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = addr_width(DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = wr_en && !full  && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc && !rd_acc)      count_d = count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en && full  && !flush;
      underflow_q <= rd_en && empty && !flush;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      assign rd_data = ram_rdata;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      // Holds across flush; only an accepted read reloads it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= ram_rdata;
      end
      assign rd_data = rd_data_q;
    end
  endgenerate

  assign count        = count_q;
  assign almost_full  = (count_q >= afull_th);
  assign almost_empty = (count_q <= aempty_th);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: three instances (32-deep standard,
// 6-deep standard, 4-deep FWFT) checked against scoreboard queues.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DEPTH=32, standard mode ----------------
  logic       a_flush = 0, a_wr = 0, a_rd = 0;
  logic [7:0] a_wdata = 0, a_rdata;
  logic [5:0] a_afth = 6'd32, a_aeth = 6'd0, a_cnt;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(32), .FWFT(0)) u32 (
    .clk(clk), .rst(rst), .flush(a_flush), .wr_en(a_wr), .wr_data(a_wdata),
    .rd_en(a_rd), .rd_data(a_rdata), .afull_th(a_afth), .aempty_th(a_aeth),
    .count(a_cnt), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .overflow(a_ovf), .underflow(a_unf));

  // ---------------- DEPTH=6, standard mode ----------------
  logic       b_flush = 0, b_wr = 0, b_rd = 0;
  logic [7:0] b_wdata = 0, b_rdata;
  logic [2:0] b_afth = 3'd5, b_aeth = 3'd2, b_cnt;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(0)) u6 (
    .clk(clk), .rst(rst), .flush(b_flush), .wr_en(b_wr), .wr_data(b_wdata),
    .rd_en(b_rd), .rd_data(b_rdata), .afull_th(b_afth), .aempty_th(b_aeth),
    .count(b_cnt), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .overflow(b_ovf), .underflow(b_unf));

  // ---------------- DEPTH=4, FWFT mode ----------------
  logic       f_flush = 0, f_wr = 0, f_rd = 0;
  logic [7:0] f_wdata = 0, f_rdata;
  logic [2:0] f_afth = 3'd4, f_aeth = 3'd0, f_cnt;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) uf (
    .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr), .wr_data(f_wdata),
    .rd_en(f_rd), .rd_data(f_rdata), .afull_th(f_afth), .aempty_th(f_aeth),
    .count(f_cnt), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf));

  logic [7:0] q32[$];
  logic [7:0] q6[$];
  logic [7:0] qf[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_b;

    // ---- reset state ----
    #12;
    check("rst_count", a_cnt, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_aempty", a_ae, 1);
    check("rst_afull", a_af, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_ovf_unf", {a_ovf, a_unf}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // ---- 1: fill 32, overflow, drain in order ----
    for (int i = 0; i < 32; i++) begin
      a_wr = 1; a_wdata = 8'(i); q32.push_back(8'(i));
      step();
    end
    a_wr = 0;
    check("t1_full", a_full, 1);
    check("t1_count32", a_cnt, 32);
    check("t1_no_ovf_yet", a_ovf, 0);
    a_wr = 1; a_wdata = 8'h20;
    step();
    a_wr = 0;
    check("t1_ovf_pulse", a_ovf, 1);
    check("t1_count_hold", a_cnt, 32);
    step();
    check("t1_ovf_one_cycle", a_ovf, 0);
    for (int i = 0; i < 32; i++) begin
      a_rd = 1;
      step();
      exp_b = q32.pop_front();
      check($sformatf("t1_rd%0d", i), a_rdata, exp_b);
    end
    a_rd = 0;
    check("t1_empty", a_empty, 1);
    check("t1_no_unf", a_unf, 0);

    // ---- 2: DEPTH=6 write/read pairs across wrap ----
    for (int i = 0; i < 20; i++) begin
      b_wr = 1; b_wdata = 8'h40 + 8'(i); q6.push_back(8'h40 + 8'(i));
      step();
      b_wr = 0;
      check($sformatf("t2_cnt1_%0d", i), b_cnt, 1);
      b_rd = 1;
      step();
      b_rd = 0;
      exp_b = q6.pop_front();
      check($sformatf("t2_rd%0d", i), b_rdata, exp_b);
      check($sformatf("t2_err%0d", i), {b_ovf, b_unf, b_cnt}, 0);
    end

    // ---- 3: almost flags while filling, threshold change mid-fill ----
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t3_ae_c%0d", k), b_ae, (k <= 2));
      check($sformatf("t3_af_c%0d", k), b_af, (k >= 5));
      if (k == 4) begin
        b_afth = 3'd3;
        #1;
        check("t3_af_th3", b_af, 1);
        b_afth = 3'd5;
        #1;
        check("t3_af_th5", b_af, 0);
      end
      b_wr = 1; b_wdata = 8'h60 + 8'(k); q6.push_back(8'h60 + 8'(k));
      step();
    end
    b_wr = 0;
    check("t3_full6", {b_full, b_cnt}, {1'b1, 3'd6});
    check("t3_af_full", b_af, 1);

    // ---- 4: simultaneous requests when full, then when empty ----
    b_wr = 1; b_rd = 1; b_wdata = 8'hEE;
    step();
    b_wr = 0; b_rd = 0;
    check("t4_ovf", b_ovf, 1);
    check("t4_cnt5", b_cnt, 5);
    exp_b = q6.pop_front();
    check("t4_rd_full", b_rdata, exp_b);
    step();
    check("t4_ovf_clear", b_ovf, 0);
    for (int i = 0; i < 5; i++) begin
      b_rd = 1;
      step();
      exp_b = q6.pop_front();
      check($sformatf("t4_drain%0d", i), b_rdata, exp_b);
    end
    b_rd = 0;
    check("t4_empty", b_empty, 1);
    b_wr = 1; b_rd = 1; b_wdata = 8'h77; q6.push_back(8'h77);
    step();
    b_wr = 0; b_rd = 0;
    check("t4_unf", b_unf, 1);
    check("t4_cnt1", b_cnt, 1);
    b_rd = 1;
    step();
    b_rd = 0;
    check("t4_unf_clear", b_unf, 0);
    exp_b = q6.pop_front();
    check("t4_no_loss", b_rdata, exp_b);

    // ---- 5: FWFT presentation ----
    check("t5_empty0", f_empty, 1);
    f_wr = 1; f_wdata = 8'hA5; qf.push_back(8'hA5);
    step();
    f_wr = 0;
    check("t5_not_empty", f_empty, 0);
    exp_b = qf[0];
    check("t5_head_a5", f_rdata, exp_b);
    f_wr = 1; f_wdata = 8'h5A; qf.push_back(8'h5A);
    step();
    f_wr = 0;
    check("t5_head_hold", f_rdata, exp_b);
    f_rd = 1;
    step();
    f_rd = 0;
    void'(qf.pop_front());
    exp_b = qf[0];
    check("t5_next_head", f_rdata, exp_b);
    f_rd = 1;
    step();
    f_rd = 0;
    void'(qf.pop_front());
    check("t5_empty_again", f_empty, 1);

    // ---- 6: flush with concurrent requests, then async reset mid-burst ----
    for (int i = 0; i < 4; i++) begin
      a_wr = 1; a_wdata = 8'hC0 + 8'(i);
      step();
    end
    a_wr = 0;
    check("t6_cnt4", a_cnt, 4);
    a_flush = 1; a_wr = 1; a_rd = 1;
    step();
    a_flush = 0; a_wr = 0; a_rd = 0;
    check("t6_flush_cnt", a_cnt, 0);
    check("t6_flush_empty", a_empty, 1);
    check("t6_flush_rdata", a_rdata, 8'h1F);
    step();
    check("t6_flush_no_err", {a_ovf, a_unf}, 0);
    q32.delete();

    for (int i = 0; i < 3; i++) begin
      a_wr = 1; a_wdata = 8'hD0 + 8'(i);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_cnt", a_cnt, 0);
    check("t6_arst_flags", {a_empty, a_full, a_ae, a_af}, 4'b1010);
    check("t6_arst_rdata", a_rdata, 0);
    check("t6_arst_err", {a_ovf, a_unf}, 0);
    a_wr = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    a_wr = 1; a_wdata = 8'h99; q32.push_back(8'h99);
    step();
    a_wr = 0; a_rd = 1;
    step();
    a_rd = 0;
    exp_b = q32.pop_front();
    check("t6_post_rst_rd", a_rdata, exp_b);
    check("t6_post_rst_empty", a_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
